pwm_fade_ctrl: RTL and testbench
================================

# pwm_fade_ctrl

Duty-cycle ramp scheduler for the multi-channel PWM peripheral. It accepts per-channel fade commands (target duty, step, interval) and walks each channel's duty register toward its target over time. All channels share the single register-write port into the PWM channel bank, and a round-robin arbiter grants that port. It sits between a command source (APB register block or a sequencer) and the `wen` / `w_data` inputs that drive the `pwmchannel` instances.

## Interface
- `NUM_CHANNELS`, default 2: number of PWM channels controlled. Must be 1 or more.
- `INTERVAL_W`, default 16: width of the per-channel update interval counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  fade command present.
- `cfg_chan`  in  $clog2(NUM_CHANNELS) (min 1)  target channel. Values of NUM_CHANNELS or more are ignored.
- `cfg_target`  in  32  final duty value.
- `cfg_step`  in  32  duty change per update. 0 means jump straight to the target.
- `cfg_interval`  in  INTERVAL_W  cycles between updates, minus 1.
- `cfg_ready`  out  1  command accepted this cycle. Constant 1 outside reset.
- `pwm_wen`  out  3*NUM_CHANNELS  one-hot write strobe in the bank layout: bit ch*3+0 is period, ch*3+1 is duty, ch*3+2 is control. Only duty bits are ever driven.
- `pwm_wdata`  out  32  write data for the strobed register.
- `busy`  out  NUM_CHANNELS  channel's current duty differs from its target.
- `done`  out  NUM_CHANNELS  1-cycle pulse when a channel reaches its target.

## Operation
- Per-channel state: `cur` (32 bits, last duty written), `target`, `step`, `interval`, a countdown `cnt`, and a `pending` flag.
- Command accept (`cfg_valid` with a legal `cfg_chan`) loads `target`, `step` and `interval`, sets `cnt = interval`, and clears `pending`. `cur` is not changed.
- Countdown, for each channel on every cycle:
  - If `cnt != 0`: `cnt` decrements.
  - Else if `cur != target`: set `pending` and reload `cnt = interval`.
  - An expiry while already pending does not queue a second request (the tick is lost).
- Arbiter: round-robin over pending channels. The search starts at `rr_ptr`. Exactly one grant per cycle at most. On a grant, `rr_ptr` becomes granted index + 1, mod NUM_CHANNELS.
- Granted channel `ch`:
  - Compute `nxt` from `cur`.
  - At the next edge: `pwm_wen[ch*3+1]=1`, `pwm_wdata=nxt`, `cur=nxt`, `pending` cleared.
- Arithmetic (unsigned):
  - Rising (`cur < target`): compute `cur+step` in 33 bits; `nxt = min(cur+step, target)`.
  - Falling (`cur > target`): `nxt = (cur-target <= step) ? target : cur-step`.
  - `step == 0`: `nxt = target`.
- `done[ch]` pulses in the same cycle as the write that makes `cur == target`.
- A command whose target already equals `cur` produces no write. In that case `done[ch]` pulses the cycle after the accept edge.
- `busy[ch] = (cur != target)`, combinational from registered state.
- Simultaneous command and grant to the same channel: the grant is suppressed (no write) and the command takes effect. Grants to other channels proceed normally.
- Reset clears all state: `cur=0`, `target=0`, `step=0`, `interval=0`, `cnt=0`, `pending=0`, `rr_ptr=0`. A fade in progress is abandoned with no further writes.

## Timing
- Reset values:
  - `pwm_wen=0`, `pwm_wdata=0`, `done=0`, `busy=0`.
  - `cfg_ready=0` while `rst` is high.
- `pwm_wen`, `pwm_wdata` and `done` are registered. `pwm_wen` is high for exactly one cycle per write. `pwm_wdata` holds its last value between writes.
- From the accept edge E0: `cnt` reaches 0 after E(interval). `pending` is set at E(interval+1). The write is visible after E(interval+2) when uncontended.
- Steady-state write spacing per channel is interval+1 cycles.
- Contention adds at most NUM_CHANNELS-1 cycles of write delay. It never loses a pending request.

## Test plan
- Rise: reset, then ch0 target=10, step=4, interval=2 -> duty writes 4, 8, 10. First `wen[1]` is 4 cycles after the accept edge, then writes every 3 cycles. `done[0]` coincides with the write of 10. `busy[0]` drops on the same edge.
- Fall with clamp: ch0 at cur=10, then target=1, step=4, interval=0 -> writes 6, 2, 1 on consecutive-plus-one cycles (spacing 1). The last step clamps to 1.
- Contention: 4 channels, all target=8, step=8, interval=0 accepted in the same window -> exactly one `wen` per cycle, in order ch0, ch1, ch2, ch3, all with data 8. Each channel gets its `done`.
- Edge cases:
  - step=0 with target=0xFFFF_FFFF from 0 -> a single write of 0xFFFF_FFFF.
  - Rising with step=0xFFFF_FFFF from cur=5 -> write clamps to the target, with no overflow wrap.
  - A command with target equal to `cur` -> no `wen`, and `done` pulses 1 cycle after accept.
- Collision and reset: re-issue a command to ch1 in its grant cycle -> no write that cycle and the new target governs.
- Reset mid-fade: assert `rst` mid-fade -> outputs at their reset values the next cycle and no further writes. An illegal `cfg_chan` is ignored.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade scheduler: walks each PWM channel's duty toward a commanded
// target and shares one register-write port across channels by round-robin.
module pwm_fade_ctrl #(
   parameter int  NUM_CHANNELS = 2,
   parameter int  INTERVAL_W   = 16,
   localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   input  logic [CHAN_W-1:0]         cfg_chan,
   input  logic [31:0]               cfg_target,
   input  logic [31:0]               cfg_step,
   input  logic [INTERVAL_W-1:0]     cfg_interval,
   output logic                      cfg_ready,
   output logic [3*NUM_CHANNELS-1:0] pwm_wen,
   output logic [31:0]               pwm_wdata,
   output logic [NUM_CHANNELS-1:0]   busy,
   output logic [NUM_CHANNELS-1:0]   done
);

   logic [31:0]               cur_r      [NUM_CHANNELS];
   logic [31:0]               target_r   [NUM_CHANNELS];
   logic [31:0]               step_r     [NUM_CHANNELS];
   logic [INTERVAL_W-1:0]     interval_r [NUM_CHANNELS];
   logic [INTERVAL_W-1:0]     cnt_r      [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]   pending_r;
   logic [CHAN_W-1:0]         rr_ptr_r;
   logic [3*NUM_CHANNELS-1:0] wen_r;
   logic [31:0]               wdata_r;
   logic [NUM_CHANNELS-1:0]   done_r;

   logic                      accept_s;
   logic [NUM_CHANNELS-1:0]   hit_s;
   logic [NUM_CHANNELS-1:0]   req_s;
   logic                      grant_valid_s;
   logic [CHAN_W-1:0]         grant_idx_s;
   logic [CHAN_W-1:0]         cand_s;
   logic [NUM_CHANNELS-1:0]   grant_oh_s;
   logic [31:0]               nxt_s;
   logic [3*NUM_CHANNELS-1:0] wen_s;
   logic [NUM_CHANNELS-1:0]   done_s;

   // Next duty value one step toward the target; the rising sum is kept in 33 bits
   function automatic logic [31:0] next_duty(input logic [31:0] cur,
                                             input logic [31:0] tgt,
                                             input logic [31:0] step);
      logic [32:0] sum;
      logic [31:0] res;
      sum = {1'b0, cur} + {1'b0, step};
      if (step == 32'd0) begin
         res = tgt;
      end else if (cur < tgt) begin
         res = (sum > {1'b0, tgt}) ? tgt : sum[31:0];
      end else if (cur > tgt) begin
         res = ((cur - tgt) <= step) ? tgt : (cur - step);
      end else begin
         res = tgt;
      end
      return res;
   endfunction

   // Channel index base+off, wrapped modulo NUM_CHANNELS
   function automatic logic [CHAN_W-1:0] wrap_idx(input logic [CHAN_W-1:0] base,
                                                  input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_CHANNELS) begin
         sum = sum - NUM_CHANNELS;
      end else begin
         sum = sum;
      end
      return CHAN_W'(sum);
   endfunction

   // Command decode; a channel being reconfigured this cycle is withheld from arbitration
   always_comb begin
      accept_s = cfg_valid && (32'(cfg_chan) < 32'(NUM_CHANNELS));
      hit_s    = {NUM_CHANNELS{1'b0}};
      req_s    = {NUM_CHANNELS{1'b0}};
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         hit_s[ch] = accept_s && (cfg_chan == CHAN_W'(ch));
         req_s[ch] = pending_r[ch] && !hit_s[ch];
      end
   end

   // Round-robin search; walking offsets downward lets the nearest request win
   always_comb begin
      grant_idx_s = {CHAN_W{1'b0}};
      cand_s      = {CHAN_W{1'b0}};
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         cand_s      = wrap_idx(rr_ptr_r, i);
         grant_idx_s = req_s[cand_s] ? cand_s : grant_idx_s;
      end
      grant_valid_s = |req_s;
   end

   // Granted channel's next duty, write strobes and completion pulses
   always_comb begin
      nxt_s      = next_duty(cur_r[grant_idx_s], target_r[grant_idx_s], step_r[grant_idx_s]);
      grant_oh_s = {NUM_CHANNELS{1'b0}};
      wen_s      = {(3*NUM_CHANNELS){1'b0}};
      done_s     = {NUM_CHANNELS{1'b0}};
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         grant_oh_s[ch]    = grant_valid_s && (grant_idx_s == CHAN_W'(ch));
         wen_s[ch*3 +: 3]  = {1'b0, grant_oh_s[ch], 1'b0};
         done_s[ch]        = (hit_s[ch] && (cfg_target == cur_r[ch])) ||
                             (grant_oh_s[ch] && (nxt_s == target_r[ch]));
      end
   end

   // Per-channel fade state: command load, countdown and pending request
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            cur_r[ch]      <= 32'd0;
            target_r[ch]   <= 32'd0;
            step_r[ch]     <= 32'd0;
            interval_r[ch] <= {INTERVAL_W{1'b0}};
            cnt_r[ch]      <= {INTERVAL_W{1'b0}};
            pending_r[ch]  <= 1'b0;
         end
      end else begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (hit_s[ch]) begin
               target_r[ch]   <= cfg_target;
               step_r[ch]     <= cfg_step;
               interval_r[ch] <= cfg_interval;
               cnt_r[ch]      <= cfg_interval;
               pending_r[ch]  <= 1'b0;
            end else begin
               if (grant_oh_s[ch]) begin
                  cur_r[ch] <= nxt_s;
               end else begin
                  cur_r[ch] <= cur_r[ch];
               end
               // An expiry on the grant edge re-arms against the freshly written duty
               if (cnt_r[ch] != {INTERVAL_W{1'b0}}) begin
                  cnt_r[ch]     <= cnt_r[ch] - INTERVAL_W'(1);
                  pending_r[ch] <= pending_r[ch] && !grant_oh_s[ch];
               end else if ((grant_oh_s[ch] ? nxt_s : cur_r[ch]) != target_r[ch]) begin
                  cnt_r[ch]     <= interval_r[ch];
                  pending_r[ch] <= 1'b1;
               end else begin
                  pending_r[ch] <= 1'b0;
               end
            end
         end
      end
   end

   // Arbiter pointer and registered write-port outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r <= {CHAN_W{1'b0}};
         wen_r    <= {(3*NUM_CHANNELS){1'b0}};
         wdata_r  <= 32'd0;
         done_r   <= {NUM_CHANNELS{1'b0}};
      end else begin
         wen_r  <= wen_s;
         done_r <= done_s;
         if (grant_valid_s) begin
            rr_ptr_r <= wrap_idx(grant_idx_s, 1);
            wdata_r  <= nxt_s;
         end else begin
            rr_ptr_r <= rr_ptr_r;
            wdata_r  <= wdata_r;
         end
      end
   end

   // Busy reflects registered duty versus target
   always_comb begin
      busy = {NUM_CHANNELS{1'b0}};
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         busy[ch] = (cur_r[ch] != target_r[ch]);
      end
   end

   assign cfg_ready = !rst;
   assign pwm_wen   = wen_r;
   assign pwm_wdata = wdata_r;
   assign done      = done_r;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with five channels (cfg_chan 5..7 illegal).
module tb_pwm_fade_ctrl;

   localparam int NCH = 5;
   localparam int IW  = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_valid;
   logic [2:0]      cfg_chan;
   logic [31:0]     cfg_target;
   logic [31:0]     cfg_step;
   logic [IW-1:0]   cfg_interval;
   logic            cfg_ready;
   logic [3*NCH-1:0] pwm_wen;
   logic [31:0]     pwm_wdata;
   logic [NCH-1:0]  busy;
   logic [NCH-1:0]  done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] exp_wen;

   pwm_fade_ctrl #(.NUM_CHANNELS(NCH), .INTERVAL_W(IW)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_chan(cfg_chan),
      .cfg_target(cfg_target), .cfg_step(cfg_step), .cfg_interval(cfg_interval),
      .cfg_ready(cfg_ready), .pwm_wen(pwm_wen), .pwm_wdata(pwm_wdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [2:0] ch, input logic [31:0] tgt,
                      input logic [31:0] stp, input logic [IW-1:0] ivl);
      cfg_valid    = 1'b1;
      cfg_chan     = ch;
      cfg_target   = tgt;
      cfg_step     = stp;
      cfg_interval = ivl;
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_chan = 3'd0;
      cfg_target = 32'd0; cfg_step = 32'd0; cfg_interval = 16'd0;
      tick(); tick();
      chk("rst_ready", 64'(cfg_ready), 64'd0);
      chk("rst_wen",   64'(pwm_wen),   64'd0);
      chk("rst_wdata", 64'(pwm_wdata), 64'd0);
      chk("rst_done",  64'(done),      64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      rst = 1'b0;
      tick();
      chk("ready", 64'(cfg_ready), 64'd1);

      // Rise 0 -> 10 by 4, interval 2: writes 4,8,10 at E4,E7,E10
      cmd(3'd0, 32'd10, 32'd4, 16'd2);
      tick();
      cfg_valid = 1'b0;
      chk("rise_busy0", 64'(busy), 64'h01);
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_wen = (k == 4 || k == 7 || k == 10) ? 64'h2 : 64'h0;
         chk("rise_wen", 64'(pwm_wen), exp_wen);
         chk("rise_done", 64'(done), (k == 10) ? 64'h1 : 64'h0);
         if (k == 4) chk("rise_d4", 64'(pwm_wdata), 64'd4);
         if (k == 7) chk("rise_d8", 64'(pwm_wdata), 64'd8);
         if (k == 10) chk("rise_d10", 64'(pwm_wdata), 64'd10);
         if (k >= 9) chk("rise_busy", 64'(busy), (k == 9) ? 64'h1 : 64'h0);
      end

      // Fall 10 -> 1 by 4, interval 0: writes 6,2,1 back to back
      cmd(3'd0, 32'd1, 32'd4, 16'd0);
      tick();
      cfg_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("fall_wen", 64'(pwm_wen), (k >= 2 && k <= 4) ? 64'h2 : 64'h0);
         chk("fall_done", 64'(done), (k == 4) ? 64'h1 : 64'h0);
         if (k == 2) chk("fall_d6", 64'(pwm_wdata), 64'd6);
         if (k == 3) chk("fall_d2", 64'(pwm_wdata), 64'd2);
         if (k == 4) chk("fall_d1", 64'(pwm_wdata), 64'd1);
      end

      // step 0 jumps straight to all-ones on ch1
      cmd(3'd1, 32'hFFFF_FFFF, 32'd0, 16'd0);
      tick();
      cfg_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("jump_wen", 64'(pwm_wen), (k == 2) ? 64'h10 : 64'h0);
         chk("jump_done", 64'(done), (k == 2) ? 64'h2 : 64'h0);
         if (k == 2) chk("jump_data", 64'(pwm_wdata), 64'hFFFF_FFFF);
      end

      // ch2 to 5, then a huge step must clamp at 100 rather than wrap
      cmd(3'd2, 32'd5, 32'd0, 16'd0);
      tick();
      cfg_valid = 1'b0;
      tick(); tick();
      chk("pre5_wen", 64'(pwm_wen), 64'h80);
      chk("pre5_data", 64'(pwm_wdata), 64'd5);
      tick();
      cmd(3'd2, 32'd100, 32'hFFFF_FFFF, 16'd0);
      tick();
      cfg_valid = 1'b0;
      tick(); tick();
      chk("clamp_wen", 64'(pwm_wen), 64'h80);
      chk("clamp_data", 64'(pwm_wdata), 64'd100);
      chk("clamp_done", 64'(done), 64'h4);
      tick();
      chk("clamp_busy", 64'(busy), 64'h0);

      // Target equal to cur: no write, done right after the accept edge
      cmd(3'd2, 32'd100, 32'd1, 16'd0);
      tick();
      cfg_valid = 1'b0;
      chk("eq_done", 64'(done), 64'h4);
      chk("eq_wen0", 64'(pwm_wen), 64'h0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("eq_wen", 64'(pwm_wen), 64'h0);
         chk("eq_done_off", 64'(done), 64'h0);
      end

      // Re-issue to ch1 on its grant cycle: no write, new target governs
      cmd(3'd1, 32'hF0, 32'h10, 16'd0);
      tick();
      cfg_valid = 1'b0;
      chk("coll_busy", 64'(busy), 64'h02);
      tick();
      chk("coll_wen_e1", 64'(pwm_wen), 64'h0);
      cmd(3'd1, 32'h200, 32'd0, 16'd1);
      tick();
      cfg_valid = 1'b0;
      chk("coll_nowrite", 64'(pwm_wen), 64'h0);
      chk("coll_busy2", 64'(busy), 64'h02);
      tick();
      chk("coll_wen_e3", 64'(pwm_wen), 64'h0);
      tick();
      chk("coll_wen_e4", 64'(pwm_wen), 64'h0);
      tick();
      chk("coll_wen_e5", 64'(pwm_wen), 64'h10);
      chk("coll_data", 64'(pwm_wdata), 64'h200);
      chk("coll_done", 64'(done), 64'h2);
      tick();
      chk("coll_idle", 64'(busy), 64'h0);

      // Illegal channel numbers are ignored
      cmd(3'd6, 32'd7, 32'd0, 16'd0);
      tick();
      cmd(3'd5, 32'd7, 32'd0, 16'd0);
      tick();
      cfg_valid = 1'b0;
      chk("illegal_busy", 64'(busy), 64'h0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("illegal_wen", 64'(pwm_wen), 64'h0);
      end

      // Contention from reset: intervals staggered so ch0..ch3 all go pending at E4
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         cmd(3'(c), 32'd8, 32'd8, 16'(3 - c));
         tick();
      end
      cfg_valid = 1'b0;
      for (int k = 4; k <= 9; k++) begin
         tick();
         exp_wen = (k == 5) ? 64'h2 : (k == 6) ? 64'h10 : (k == 7) ? 64'h80 :
                   (k == 8) ? 64'h400 : 64'h0;
         chk("cont_wen", 64'(pwm_wen), exp_wen);
         chk("cont_done", 64'(done), (k >= 5 && k <= 8) ? (64'd1 << (k - 5)) : 64'h0);
         if (k >= 5 && k <= 8) chk("cont_data", 64'(pwm_wdata), 64'd8);
         if (k == 4) chk("cont_busy4", 64'(busy), 64'h0F);
         if (k == 8) chk("cont_busy8", 64'(busy), 64'h00);
      end

      // Reset mid-fade
      cmd(3'd0, 32'h100, 32'd1, 16'd0);
      tick();
      cfg_valid = 1'b0;
      tick();
      chk("mid_wen_e1", 64'(pwm_wen), 64'h0);
      tick();
      chk("mid_wen_e2", 64'(pwm_wen), 64'h2);
      chk("mid_d9", 64'(pwm_wdata), 64'd9);
      tick();
      chk("mid_d10", 64'(pwm_wdata), 64'd10);
      rst = 1'b1;
      tick();
      chk("mid_rst_wen",   64'(pwm_wen),   64'h0);
      chk("mid_rst_wdata", 64'(pwm_wdata), 64'h0);
      chk("mid_rst_done",  64'(done),      64'h0);
      chk("mid_rst_busy",  64'(busy),      64'h0);
      chk("mid_rst_ready", 64'(cfg_ready), 64'h0);
      rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("post_rst_wen", 64'(pwm_wen), 64'h0);
         chk("post_rst_busy", 64'(busy), 64'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
